// File: rtl/cmsdk_mcu_clken_gen.sv
// cmsdk_mcu_clken_gen
// Multi-channel programmable clock-enable generator for the Cortex-M0 MCU.
// Each channel divides FCLK by its own ratio, in toggle or pulse mode.
// Channel settings come in through a single-entry valid/ready slot. The
// slot's contents are written into the channel only at a terminal count,
// or at once if the channel is disabled, so an output never glitches.

module cmsdk_mcu_clken_gen #(
  parameter int          NUM_CH      = 2,
  parameter int          DIV_W       = 18,
  parameter int          DEFAULT_DIV = 1000,
  parameter logic [23:0] CALIB_10MS  = 24'd0,
  parameter logic        NOREF       = 1'b0
) (
  input  logic              FCLK,
  input  logic              SYSRESET,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [3:0]        CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic              CFG_MODE,
  input  logic              CFG_EN,
  output logic              CFG_ERR,
  output logic [NUM_CH-1:0] CLKEN,
  output logic [25:0]       STCALIB
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  // Per-channel state
  logic [DIV_W-1:0]  cnt [NUM_CH];
  logic [DIV_W-1:0]  div [NUM_CH];
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] clken;

  // Single pending configuration entry
  logic              pend_valid;
  logic [3:0]        pend_ch;
  logic [DIV_W-1:0]  pend_div;
  logic              pend_mode;
  logic              pend_en;
  logic              cfg_err;

  logic              accept;
  logic              req_bad;
  logic [NUM_CH-1:0] apply;

  // Toggle mode counts half periods, pulse mode counts whole periods
  function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] n,
                                                 input logic m);
    return m ? (n - DIV_W'(1)) : ((n >> 1) - DIV_W'(1));
  endfunction

  assign CFG_READY = ~pend_valid;
  assign CFG_ERR   = cfg_err;
  assign CLKEN     = clken;
  assign STCALIB   = {NOREF, (CALIB_10MS == 24'd0), CALIB_10MS};

  assign accept  = CFG_VALID && CFG_READY;
  assign req_bad = ({1'b0, CFG_CH} >= 5'(NUM_CH)) ||
                   (CFG_EN && (CFG_DIV == '0)) ||
                   (CFG_EN && !CFG_MODE && (CFG_DIV[0] || (CFG_DIV < DIV_W'(2))));

  // A pending entry lands on its channel when that channel is idle or at terminal count
  always_comb begin
    apply = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      apply[i] = pend_valid && (pend_ch == 4'(i)) && (!en[i] || (cnt[i] == '0));
    end
  end

  // Accept or reject requests into the pending slot; the slot frees on apply
  always_ff @(posedge FCLK) begin
    if (SYSRESET) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
      pend_mode  <= 1'b0;
      pend_en    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= accept && req_bad;
      if (accept && !req_bad) begin
        pend_valid <= 1'b1;
        pend_ch    <= CFG_CH;
        pend_div   <= CFG_DIV;
        pend_mode  <= CFG_MODE;
        pend_en    <= CFG_EN;
      end else if (|apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Channel counters and outputs, with a new setting loaded at its apply cycle
  always_ff @(posedge FCLK) begin
    if (SYSRESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]   <= '0;
        div[i]   <= DEF_DIV;
        mode[i]  <= 1'b0;
        en[i]    <= 1'b1;
        clken[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply[i]) begin
          div[i]  <= pend_div;
          mode[i] <= pend_mode;
          en[i]   <= pend_en;
          if (pend_en) begin
            cnt[i] <= reload_of(pend_div, pend_mode);
            if (en[i]) begin
              clken[i] <= pend_mode ? 1'b1 : ~clken[i];
            end else begin
              clken[i] <= 1'b0;
            end
          end else begin
            cnt[i]   <= '0;
            clken[i] <= 1'b0;
          end
        end else if (!en[i]) begin
          cnt[i]   <= '0;
          clken[i] <= 1'b0;
        end else if (cnt[i] == '0) begin
          cnt[i]   <= reload_of(div[i], mode[i]);
          clken[i] <= mode[i] ? 1'b1 : ~clken[i];
        end else begin
          cnt[i] <= cnt[i] - DIV_W'(1);
          if (mode[i]) begin
            clken[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmsdk_mcu_clken_gen.sv
// Testbench for cmsdk_mcu_clken_gen with NUM_CH=2, DEFAULT_DIV=1000.
// Expected per-cycle outputs are derived from the intended behaviour,
// queued as each edge is driven and compared once that edge has passed.

module tb_cmsdk_mcu_clken_gen;

  localparam int DIV_W = 18;

  logic             FCLK = 1'b0;
  logic             SYSRESET = 1'b1;
  logic             CFG_VALID = 1'b0;
  logic             CFG_READY;
  logic [3:0]       CFG_CH = 4'd0;
  logic [DIV_W-1:0] CFG_DIV = '0;
  logic             CFG_MODE = 1'b0;
  logic             CFG_EN = 1'b0;
  logic             CFG_ERR;
  logic [1:0]       CLKEN;
  logic [25:0]      STCALIB;

  typedef struct packed {
    logic [1:0] clken;
    logic       ready;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  cmsdk_mcu_clken_gen #(
    .NUM_CH(2),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(1000),
    .CALIB_10MS(24'd0),
    .NOREF(1'b0)
  ) dut (
    .FCLK(FCLK),
    .SYSRESET(SYSRESET),
    .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY),
    .CFG_CH(CFG_CH),
    .CFG_DIV(CFG_DIV),
    .CFG_MODE(CFG_MODE),
    .CFG_EN(CFG_EN),
    .CFG_ERR(CFG_ERR),
    .CLKEN(CLKEN),
    .STCALIB(STCALIB)
  );

  always #5 FCLK = ~FCLK;

  // One rising edge, then settle to the falling edge for sampling and driving
  task automatic tick();
    @(posedge FCLK);
    @(negedge FCLK);
  endtask

  // Default channel after reset release: high for edges 1..500, low 501..1000, ...
  function automatic logic def_ch(input int p);
    return (p >= 1) && (((p - 1) / 500) % 2 == 0);
  endfunction

  task automatic do_reset();
    SYSRESET  = 1'b1;
    CFG_VALID = 1'b0;
    repeat (3) tick();
    SYSRESET = 1'b0;
  endtask

  task automatic set_req(input logic v, input logic [3:0] ch, input int n,
                         input logic m, input logic e);
    CFG_VALID = v;
    CFG_CH    = ch;
    CFG_DIV   = DIV_W'(n);
    CFG_MODE  = m;
    CFG_EN    = e;
  endtask

  task automatic test_reset();
    exp_t e;
    SYSRESET = 1'b1;
    set_req(1'b1, 4'd1, 4, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{clken: 2'b00, ready: 1'b1, err: 1'b0});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_hold k=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 k, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
    vectors++;
    if (STCALIB !== 26'h1000000) begin
      miscompares++;
      $display("[TB] FAIL stcalib got %h want %h", STCALIB, 26'h1000000);
    end
    CFG_VALID = 1'b0;
    SYSRESET  = 1'b0;
    for (int p = 1; p <= 1010; p++) begin
      sb.push_back('{clken: {def_ch(p), def_ch(p)}, ready: 1'b1, err: 1'b0});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_defaults p=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 p, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
  endtask

  task automatic test_pulse_reprogram();
    exp_t e;
    logic [1:0] cl;
    do_reset();
    for (int p = 1; p <= 540; p++) begin
      set_req(p == 101, 4'd1, 4, 1'b1, 1'b1);
      cl[0] = def_ch(p);
      cl[1] = (p >= 501) ? ((p - 501) % 4 == 0) : def_ch(p);
      sb.push_back('{clken: cl, ready: !(p >= 101 && p <= 500), err: 1'b0});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL pulse_reprogram p=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 p, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
    CFG_VALID = 1'b0;
  endtask

  task automatic test_rejects();
    exp_t e;
    logic [1:0] cl;
    do_reset();
    for (int p = 1; p <= 1010; p++) begin
      case (p)
        11:      set_req(1'b1, 4'd1, 5, 1'b0, 1'b1);
        21:      set_req(1'b1, 4'd3, 4, 1'b0, 1'b1);
        31:      set_req(1'b1, 4'd0, 0, 1'b1, 1'b1);
        41:      set_req(1'b1, 4'd1, 0, 1'b0, 1'b0);
        default: set_req(1'b0, 4'd0, 0, 1'b0, 1'b0);
      endcase
      cl[0] = def_ch(p);
      cl[1] = (p >= 501) ? 1'b0 : def_ch(p);
      sb.push_back('{clken: cl, ready: !(p >= 41 && p <= 500),
                     err: (p == 11) || (p == 21) || (p == 31)});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL rejects p=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 p, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
    CFG_VALID = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [1:0] cl;
    do_reset();
    for (int p = 1; p <= 540; p++) begin
      if (p == 11) set_req(1'b1, 4'd0, 6, 1'b0, 1'b1);
      else if (p >= 12 && p <= 502) set_req(1'b1, 4'd0, 10, 1'b1, 1'b1);
      else set_req(1'b0, 4'd0, 0, 1'b0, 1'b0);
      if (p <= 500) cl[0] = def_ch(p);
      else if (p <= 503) cl[0] = 1'b0;
      else cl[0] = ((p - 504) % 10 == 0);
      cl[1] = def_ch(p);
      sb.push_back('{clken: cl,
                     ready: !((p >= 11 && p <= 500) || (p >= 502 && p <= 503)),
                     err: 1'b0});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL back_to_back p=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 p, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
    CFG_VALID = 1'b0;
  endtask

  task automatic test_disable_enable();
    exp_t e;
    logic [1:0] cl;
    do_reset();
    for (int p = 1; p <= 1080; p++) begin
      if (p == 11) set_req(1'b1, 4'd0, 0, 1'b0, 1'b0);
      else if (p == 1051) set_req(1'b1, 4'd0, 8, 1'b0, 1'b1);
      else set_req(1'b0, 4'd0, 0, 1'b0, 1'b0);
      if (p <= 500) cl[0] = def_ch(p);
      else if (p < 1056) cl[0] = 1'b0;
      else cl[0] = (((p - 1056) / 4) % 2 == 0);
      cl[1] = def_ch(p);
      sb.push_back('{clken: cl, ready: !((p >= 11 && p <= 500) || p == 1051), err: 1'b0});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL disable_enable p=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 p, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
    CFG_VALID = 1'b0;
  endtask

  task automatic test_same_cycle();
    exp_t e;
    logic [1:0] cl;
    do_reset();
    for (int p = 1; p <= 510; p++) begin
      set_req(p == 1, 4'd1, 4, 1'b1, 1'b1);
      cl[0] = def_ch(p);
      cl[1] = (p >= 501) ? ((p - 501) % 4 == 0) : def_ch(p);
      sb.push_back('{clken: cl, ready: !(p >= 1 && p <= 500), err: 1'b0});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL same_cycle p=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 p, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
    CFG_VALID = 1'b0;
  endtask

  task automatic test_reset_midop();
    exp_t e;
    do_reset();
    for (int p = 1; p <= 200; p++) begin
      set_req(p == 11, 4'd1, 4, 1'b1, 1'b1);
      sb.push_back('{clken: {def_ch(p), def_ch(p)}, ready: !(p >= 11), err: 1'b0});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL midop_pre p=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 p, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
    SYSRESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{clken: 2'b00, ready: 1'b1, err: 1'b0});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL midop_reset k=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 k, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
    SYSRESET = 1'b0;
    for (int p = 1; p <= 1010; p++) begin
      sb.push_back('{clken: {def_ch(p), def_ch(p)}, ready: 1'b1, err: 1'b0});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({CLKEN, CFG_READY, CFG_ERR} !== e) begin
        miscompares++;
        $display("[TB] FAIL midop_post p=%0d got clken=%b ready=%b err=%b want clken=%b ready=%b err=%b",
                 p, CLKEN, CFG_READY, CFG_ERR, e.clken, e.ready, e.err);
      end
    end
  endtask

  initial begin
    @(negedge FCLK);
    $display("[TB] starting");
    test_reset();
    test_pulse_reprogram();
    test_rejects();
    test_back_to_back();
    test_disable_enable();
    test_same_cycle();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmsdk_mcu_clken_gen.md
# cmsdk_mcu_clken_gen

Multi-channel, run-time-programmable clock-enable generator for the Cortex-M0 MCU subsystem. It produces one divided enable per channel from the free-running FCLK. Channel 0 normally drives the processor SysTick STCLKEN; the other channels feed timers and peripherals. Each channel has its own divider, output mode and enable. Configuration is accepted through a valid/ready port and applied glitch-free at the channel's terminal count.

## Interface
- NUM_CH, 2: number of channels, 1..16.
- DIV_W, 18: divider width in bits.
- DEFAULT_DIV, 1000: divide ratio of every channel after reset. Must be even and ≥2.
- CALIB_10MS, 24'd0: STCALIB[23:0] value.
- NOREF, 1'b0: STCALIB[25] value.
- FCLK  in  1  free-running clock; the only clock.
- SYSRESET  in  1  reset, synchronous and active-high.
- CFG_VALID  in  1  configuration request.
- CFG_READY  out  1  high when a request can be accepted.
- CFG_CH  in  4  target channel.
- CFG_DIV  in  DIV_W  divide ratio N.
- CFG_MODE  in  1  0 = toggle (50% duty, period N), 1 = pulse (one-cycle high every N).
- CFG_EN  in  1  channel enable.
- CFG_ERR  out  1  one-cycle pulse: the last accepted request was rejected.
- CLKEN  out  NUM_CH  per-channel enable outputs, registered.
- STCALIB  out  26  {NOREF, SKEW, CALIB_10MS}, where SKEW = (CALIB_10MS==0). Constant.

## Operation
**Per-channel state**
- cnt (DIV_W), div, mode, en.
- reload = mode ? N-1 : (N>>1)-1.

**Enabled channel, each cycle**
- If cnt != 0: cnt <= cnt-1.
- If cnt == 0: cnt <= reload, and the output event fires.
  - Toggle mode: CLKEN[i] <= ~CLKEN[i].
  - Pulse mode: CLKEN[i] <= 1.
- Pulse mode, all other cycles: CLKEN[i] <= 0.
- Pulse mode with N=1 holds CLKEN[i] high continuously.

**Disabled channel**
- cnt held at 0, CLKEN[i] <= 0.

**Handshake**
- A transfer occurs when CFG_VALID && CFG_READY on a rising FCLK edge.
- There is a single pending slot. CFG_READY = ~pending_valid.

**Validation at acceptance**
- The request is rejected (no pending entry, CFG_ERR=1 on the next cycle) if any of these hold:
  - CFG_CH ≥ NUM_CH
  - CFG_EN=1 and CFG_DIV=0
  - CFG_EN=1, CFG_MODE=0 and CFG_DIV is odd or less than 2
- With CFG_EN=0, CFG_DIV and CFG_MODE are ignored (not checked).

**Applying a pending entry**
- The entry applies on the first cycle where the target channel is disabled, or is enabled with cnt==0. On that cycle:
  - div/mode/en are loaded.
  - The output event uses the NEW mode.
  - If the new en=1: cnt <= new reload.
  - If the new en=0: cnt <= 0 and CLKEN[i] <= 0.
- Enabling a disabled channel: cnt <= reload and CLKEN[i] stays 0. The first event comes reload+1 cycles later.
- pending_valid clears on the apply cycle, so CFG_READY is high on the next cycle.
- Other channels are never disturbed by a configuration aimed elsewhere.

## Timing
- **Reset values:** CLKEN=0, CFG_READY=1, CFG_ERR=0. All channels en=1, mode=toggle, div=DEFAULT_DIV, cnt=0, no pending entry.
- **First edge after reset:** on the first clock after SYSRESET deasserts, cnt==0, so CLKEN toggles to 1 then. Toggles follow every DEFAULT_DIV/2 cycles.
- **Config latency:**
  - Target disabled: applied 1 cycle after acceptance.
  - Target enabled: applied at the next cnt==0. Worst case is reload+1 cycles after acceptance.
- **Accept and apply on the same cycle:** a request accepted while the target's cnt==0 is NOT applied that cycle. It applies at the following terminal count, or next cycle if disabled.
- **Reset mid-operation:** SYSRESET dominates all inputs. The pending entry is discarded, and CFG_ERR and CLKEN clear on that edge.
- **Counter arithmetic:** modulo 2^DIV_W. cnt never underflows because it reloads at 0.

## Test plan
- **Reset defaults (NUM_CH=2, DEFAULT_DIV=1000):** release reset → both CLKEN rise 1 cycle later and toggle every 500 cycles. STCALIB=26'h1000000.
- **Pulse reprogram:** ch1, N=4, mode=1, en=1, accepted mid-period → old toggle period completes, then CLKEN[1] is high 1 cycle in every 4. CFG_READY is low until the apply cycle. CLKEN[0] is unaffected.
- **Rejected requests:**
  - ch1, toggle, N=5 → CFG_ERR pulses 1 cycle, ch1 unchanged.
  - CFG_CH=3 → CFG_ERR pulses.
  - CFG_EN=1 with CFG_DIV=0 → CFG_ERR pulses.
- **Back-pressure:** two back-to-back requests to ch0 (N=1000 running) → second is held (CFG_READY=0) until the first applies, then accepted.
- **Disable/enable:**
  - ch0 en=0 → CLKEN[0]=0 from the terminal-count cycle onward.
  - Then en=1, N=8, toggle → applied 1 cycle after acceptance, first toggle 4 cycles after apply, period 8.
- **Reset mid-op:** assert SYSRESET while a request is pending → pending is dropped, CLKEN=0, defaults resume exactly as in the first scenario.
